// File: rtl/cc_wb_pkg.sv
// Shared types and default sizes for the register-file writeback front end.
package cc_wb_pkg;

    localparam int DATA_W_DEF     = 64;
    localparam int ADDR_W_DEF     = 5;
    localparam int FIFO_DEPTH_DEF = 4;

    // One register-file write request: destination and value.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO for writeback requests. Push and pop may happen in
// the same cycle, including when full; DEPTH must be a power of two.
module wb_sync_fifo
    import cc_wb_pkg::*;
#(
    parameter type T     = wb_req_t,
    parameter int  DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    T              mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests: never pop when empty, never push when full unless a pop frees a slot.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == '0);

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Owns the register file write port: ALU writebacks take priority, queued
// measurement results fill idle cycles, and a pending scoreboard stalls decode
// on registers whose measurement result has not been committed yet.
module reg_writeback_arbiter
    import cc_wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_wr_en,
    input  logic [ADDR_W-1:0]    alu_wr_addr,
    input  logic [DATA_W-1:0]    alu_wr_data,
    input  logic                 meas_issue,
    input  logic [ADDR_W-1:0]    meas_issue_addr,
    input  logic                 meas_valid,
    output logic                 meas_ready,
    input  logic [ADDR_W-1:0]    meas_addr,
    input  logic [DATA_W-1:0]    meas_data,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic                 stall,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 wr_conflict
);

    localparam int NREG = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              push_req_s;
    req_t              head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              meas_ready_s;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              src_is_meas_r;
    logic              wr_conflict_r;
    logic [NREG-1:0]   pending_r;
    logic [NREG-1:0]   pending_nxt_s;

    // Handshake and arbitration: the FIFO head is only consumed when the ALU is idle.
    always_comb begin
        meas_ready_s = !fifo_full_s && !reset;
        fifo_push_s  = meas_valid && meas_ready_s;
        fifo_pop_s   = !alu_wr_en && !fifo_empty_s;
        push_req_s   = '{addr: meas_addr, data: meas_data};
    end

    wb_sync_fifo #(
        .T     (req_t),
        .DEPTH (FIFO_DEPTH)
    ) u_meas_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (push_req_s),
        .pop       (fifo_pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Output register stage: r0 writes are consumed but never raise wr_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_r       <= 1'b0;
            wr_addr_r     <= '0;
            wr_data_r     <= '0;
            src_is_meas_r <= 1'b0;
            wr_conflict_r <= 1'b0;
        end else if (alu_wr_en) begin
            wr_en_r       <= (alu_wr_addr != '0);
            wr_addr_r     <= alu_wr_addr;
            wr_data_r     <= alu_wr_data;
            src_is_meas_r <= 1'b0;
            wr_conflict_r <= (alu_wr_addr != '0) && pending_r[alu_wr_addr];
        end else if (!fifo_empty_s) begin
            wr_en_r       <= (head_s.addr != '0);
            wr_addr_r     <= head_s.addr;
            wr_data_r     <= head_s.data;
            src_is_meas_r <= 1'b1;
            wr_conflict_r <= 1'b0;
        end else begin
            wr_en_r       <= 1'b0;
            src_is_meas_r <= 1'b0;
            wr_conflict_r <= 1'b0;
        end
    end

    // Scoreboard update: clear on a presented measurement commit, then apply a new issue so it wins.
    always_comb begin
        pending_nxt_s = pending_r;
        if (wr_en_r && src_is_meas_r) begin
            pending_nxt_s[wr_addr_r] = 1'b0;
        end else begin
            pending_nxt_s[wr_addr_r] = pending_r[wr_addr_r];
        end
        if (meas_issue && (meas_issue_addr != '0)) begin
            pending_nxt_s[meas_issue_addr] = 1'b1;
        end else begin
            pending_nxt_s[meas_issue_addr] = pending_nxt_s[meas_issue_addr];
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Scoreboard register; reset discards all outstanding measurements.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Decode stall: r0 is never pending, and there is no forwarding path.
    always_comb begin
        stall = ((rs_addr != '0) && pending_r[rs_addr]) ||
                ((rt_addr != '0) && pending_r[rt_addr]);
    end

    assign meas_ready  = meas_ready_s;
    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign pending     = pending_r;
    assign wr_conflict = wr_conflict_r;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter with a write scoreboard.
module tb_reg_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_wr_en;
    logic [4:0]  alu_wr_addr;
    logic [63:0] alu_wr_data;
    logic        meas_issue;
    logic [4:0]  meas_issue_addr;
    logic        meas_valid;
    logic        meas_ready;
    logic [4:0]  meas_addr;
    logic [63:0] meas_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [31:0] pending;
    logic        wr_conflict;

    reg_writeback_arbiter #(.DATA_W(64), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_wr_en(alu_wr_en), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
        .meas_issue(meas_issue), .meas_issue_addr(meas_issue_addr),
        .meas_valid(meas_valid), .meas_ready(meas_ready),
        .meas_addr(meas_addr), .meas_data(meas_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending(pending), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [63:0] data;
    } alu_exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } meas_exp_t;

    alu_exp_t  alu_q [$];
    meas_exp_t meas_q [$];
    int        cyc = 0;
    int        n_cmp = 0;
    int        n_err = 0;
    logic      rdy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Records what the DUT will accept at the coming edge, then advances to the next negedge.
    task automatic step(output logic ready_seen);
        alu_exp_t  a;
        meas_exp_t m;
        #1;
        ready_seen = meas_ready;
        if (reset) begin
            alu_q.delete();
            meas_q.delete();
        end else begin
            if (alu_wr_en && alu_wr_addr != 5'd0) begin
                a.due = cyc + 1; a.addr = alu_wr_addr; a.data = alu_wr_data;
                alu_q.push_back(a);
            end
            if (meas_valid && meas_ready && meas_addr != 5'd0) begin
                m.addr = meas_addr; m.data = meas_data;
                meas_q.push_back(m);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        alu_wr_en = 1'b0; meas_issue = 1'b0; meas_valid = 1'b0;
    endtask

    // Write-port monitor: ALU writes must land exactly one cycle later, measurement writes in arrival order.
    always @(negedge clk) begin
        alu_exp_t  a;
        meas_exp_t m;
        if (alu_q.size() > 0 && alu_q[0].due == cyc) begin
            a = alu_q.pop_front();
            chk("alu_wr_en", {63'd0, wr_en}, 64'd1);
            chk("alu_wr_addr", {59'd0, wr_addr}, {59'd0, a.addr});
            chk("alu_wr_data", wr_data, a.data);
        end else if (wr_en) begin
            if (meas_q.size() == 0) begin
                chk("spurious_wr_en", {63'd0, wr_en}, 64'd0);
            end else begin
                m = meas_q.pop_front();
                chk("meas_wr_addr", {59'd0, wr_addr}, {59'd0, m.addr});
                chk("meas_wr_data", wr_data, m.data);
            end
        end
    end

    initial begin
        int mi;
        reset = 1'b1; idle();
        alu_wr_addr = 5'd0; alu_wr_data = 64'd0; meas_issue_addr = 5'd0;
        meas_addr = 5'd0; meas_data = 64'd0; rs_addr = 5'd0; rt_addr = 5'd0;
        @(negedge clk);
        step(rdy); step(rdy);
        chk("init_wr_en", {63'd0, wr_en}, 64'd0);
        chk("init_pending", {32'd0, pending}, 64'd0);
        reset = 1'b0;
        step(rdy);
        chk("init_ready", {63'd0, rdy}, 64'd1);

        // Reset mid-traffic with a queued result and a pending bit.
        meas_issue = 1'b1; meas_issue_addr = 5'd12;
        alu_wr_en = 1'b1; alu_wr_addr = 5'd1; alu_wr_data = 64'h11;
        step(rdy);
        meas_issue = 1'b0;
        alu_wr_addr = 5'd2; alu_wr_data = 64'h22;
        meas_valid = 1'b1; meas_addr = 5'd12; meas_data = 64'hC;
        step(rdy);
        chk("pre_reset_pending12", {63'd0, pending[12]}, 64'd1);
        meas_valid = 1'b0; alu_wr_addr = 5'd3; alu_wr_data = 64'h33;
        reset = 1'b1;
        step(rdy);
        chk("rst_ready", {63'd0, rdy}, 64'd0);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_pending", {32'd0, pending}, 64'd0);
        idle();
        step(rdy);
        chk("rst2_ready", {63'd0, meas_ready}, 64'd0);
        chk("rst2_wr_en", {63'd0, wr_en}, 64'd0);
        reset = 1'b0;
        step(rdy);
        chk("post_rst_ready", {63'd0, rdy}, 64'd1);
        chk("post_rst_wr_en", {63'd0, wr_en}, 64'd0);
        step(rdy);
        chk("post_rst_wr_en2", {63'd0, wr_en}, 64'd0);

        // Single ALU write.
        alu_wr_en = 1'b1; alu_wr_addr = 5'd5; alu_wr_data = 64'hA5;
        step(rdy);
        idle();
        chk("alu5_wr_en", {63'd0, wr_en}, 64'd1);
        chk("alu5_addr", {59'd0, wr_addr}, 64'd5);
        chk("alu5_data", wr_data, 64'hA5);
        step(rdy);
        chk("alu5_once", {63'd0, wr_en}, 64'd0);

        // Measurement r7: stall window and N+2 latency.
        meas_issue = 1'b1; meas_issue_addr = 5'd7; rs_addr = 5'd7;
        step(rdy);
        meas_issue = 1'b0;
        chk("m7_stall_N", {63'd0, stall}, 64'd1);
        meas_valid = 1'b1; meas_addr = 5'd7; meas_data = 64'd1;
        step(rdy);
        meas_valid = 1'b0;
        chk("m7_stall_N1", {63'd0, stall}, 64'd1);
        chk("m7_wr_N1", {63'd0, wr_en}, 64'd0);
        step(rdy);
        chk("m7_stall_N2", {63'd0, stall}, 64'd1);
        chk("m7_wr_N2", {63'd0, wr_en}, 64'd1);
        chk("m7_addr_N2", {59'd0, wr_addr}, 64'd7);
        chk("m7_data_N2", wr_data, 64'd1);
        step(rdy);
        chk("m7_stall_N3", {63'd0, stall}, 64'd0);
        chk("m7_pending_N3", {63'd0, pending[7]}, 64'd0);
        rs_addr = 5'd0;

        // Five results against six ALU writes with a depth-4 queue.
        mi = 0;
        for (int c = 0; c < 14; c++) begin
            alu_wr_en = (c < 6); alu_wr_addr = 5'(10 + c); alu_wr_data = 64'h1000 + 64'(c);
            meas_valid = (mi < 5); meas_addr = 5'(20 + mi); meas_data = 64'h2000 + 64'(mi);
            step(rdy);
            if (c >= 4 && c <= 6) chk("burst_ready_full", {63'd0, rdy}, 64'd0);
            if (c == 7) chk("burst_ready_after_pop", {63'd0, rdy}, 64'd1);
            if (meas_valid && rdy) mi++;
        end
        idle();
        chk("burst_all_accepted", 64'(mi), 64'd5);
        chk("burst_meas_drained", 64'(meas_q.size()), 64'd0);

        // Same-edge set and clear of r3: set wins.
        meas_issue = 1'b1; meas_issue_addr = 5'd3; rt_addr = 5'd3;
        step(rdy);
        meas_issue = 1'b0;
        meas_valid = 1'b1; meas_addr = 5'd3; meas_data = 64'h33;
        step(rdy);
        meas_valid = 1'b0;
        step(rdy);
        chk("r3_commit_wr", {63'd0, wr_en}, 64'd1);
        meas_issue = 1'b1; meas_issue_addr = 5'd3;
        step(rdy);
        meas_issue = 1'b0;
        chk("r3_set_wins", {63'd0, pending[3]}, 64'd1);
        chk("r3_stall_rt", {63'd0, stall}, 64'd1);
        meas_valid = 1'b1; meas_addr = 5'd3; meas_data = 64'h34;
        step(rdy);
        idle();
        step(rdy); step(rdy);
        chk("r3_cleared", {63'd0, pending[3]}, 64'd0);
        rt_addr = 5'd0;

        // ALU write to pending r9, then writes and issue to r0.
        meas_issue = 1'b1; meas_issue_addr = 5'd9;
        step(rdy);
        meas_issue = 1'b0;
        alu_wr_en = 1'b1; alu_wr_addr = 5'd9; alu_wr_data = 64'h99;
        step(rdy);
        idle();
        chk("r9_wr_en", {63'd0, wr_en}, 64'd1);
        chk("r9_conflict", {63'd0, wr_conflict}, 64'd1);
        chk("r9_still_pending", {63'd0, pending[9]}, 64'd1);
        step(rdy);
        chk("r9_conflict_pulse", {63'd0, wr_conflict}, 64'd0);
        alu_wr_en = 1'b1; alu_wr_addr = 5'd0; alu_wr_data = 64'hFF;
        meas_issue = 1'b1; meas_issue_addr = 5'd0;
        step(rdy);
        idle();
        chk("r0_alu_no_wr", {63'd0, wr_en}, 64'd0);
        chk("r0_not_pending", {63'd0, pending[0]}, 64'd0);
        meas_valid = 1'b1; meas_addr = 5'd0; meas_data = 64'hEE;
        step(rdy);
        idle();
        step(rdy);
        chk("r0_meas_no_wr", {63'd0, wr_en}, 64'd0);
        meas_valid = 1'b1; meas_addr = 5'd9; meas_data = 64'h9A;
        step(rdy);
        idle();
        step(rdy); step(rdy); step(rdy);
        chk("final_pending", {32'd0, pending}, 64'd0);
        chk("final_alu_q", 64'(alu_q.size()), 64'd0);
        chk("final_meas_q", 64'(meas_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
